// File: rtl/regfile_param.sv
// regfile_param: parametrised MIPS general-purpose register file.
// Two combinational read ports, one synchronous write port.
// After reset, a clear sequencer zeroes every register, one per clock.
// ready stays low until the last register has been cleared.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle write data
// to a read port that addresses the register being written.
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic                  RegRead,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [ADDR_WIDTH-1:0]   clr_cnt_nxt;
    logic [DATA_WIDTH-1:0]   regs [DEPTH];
    logic                    wr_en;

    // Register 0 is hardwired to zero only when ZERO_REG is set.
    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // External writes land only in RUN and never on a hardwired-zero register.
    assign wr_en = (state == RUN) && RegWrite && !is_zero_reg(WriteReg);

    // State register: reset restarts clearing from address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next state: walk clr_cnt through every address, then enter RUN.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        if (state == CLEAR) begin
            clr_cnt_nxt = clr_cnt + ADDR_WIDTH'(1);
            if (clr_cnt == LAST_ADDR) begin
                state_nxt = RUN;
            end
        end
    end

    // Output decode: the file is usable exactly while in RUN.
    always_comb begin
        ready = (state == RUN);
    end

    // Array update: clearing has priority; the reset edge leaves contents alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                regs[clr_cnt] <= '0;
            end else if (wr_en) begin
                regs[WriteReg] <= WriteData;
            end
        end
    end

    // Read ports: gated to zero in CLEAR, when disabled, or on the zero register.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if ((state == RUN) && RegRead) begin
            if (!is_zero_reg(ReadReg1)) begin
                ReadData1 = regs[ReadReg1];
`ifdef REGFILE_WRITE_BYPASS_EN
                if (wr_en && (ReadReg1 == WriteReg)) begin
                    ReadData1 = WriteData;
                end
`endif
            end
            if (!is_zero_reg(ReadReg2)) begin
                ReadData2 = regs[ReadReg2];
`ifdef REGFILE_WRITE_BYPASS_EN
                if (wr_en && (ReadReg2 == WriteReg)) begin
                    ReadData2 = WriteData;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: scoreboard bench for regfile_param.
// Three instances: default, ZERO_REG=0, and a 16x8 variant.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite, RegRead;
    logic [4:0]  ReadReg1, ReadReg2, WriteReg;
    logic [31:0] WriteData;
    logic [31:0] a_rd1, a_rd2, z_rd1, z_rd2;
    logic        a_ready, z_ready;

    logic        s_reset;
    logic        s_we, s_re;
    logic [2:0]  s_ra1, s_ra2, s_wa;
    logic [15:0] s_wd;
    logic [15:0] s_rd1, s_rd2;
    logic        s_ready;

    always #5 clk = ~clk;

    regfile_param dut_a (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .RegRead(RegRead),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadData1(a_rd1), .ReadData2(a_rd2), .ready(a_ready)
    );

    regfile_param #(.ZERO_REG(0)) dut_z (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .RegRead(RegRead),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadData1(z_rd1), .ReadData2(z_rd2), .ready(z_ready)
    );

    regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut_s (
        .clk(clk), .reset(s_reset), .RegWrite(s_we), .RegRead(s_re),
        .ReadReg1(s_ra1), .ReadReg2(s_ra2), .WriteReg(s_wa),
        .WriteData(s_wd), .ReadData1(s_rd1), .ReadData2(s_rd2), .ready(s_ready)
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0: return a_rd1;
            1: return a_rd2;
            2: return {31'b0, a_ready};
            3: return z_rd1;
            4: return {31'b0, z_ready};
            5: return {16'b0, s_rd1};
            6: return {31'b0, s_ready};
            default: return 32'hxxxxxxxx;
        endcase
    endfunction

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            c   = q.pop_front();
            act = observe(c.sel);
            checks++;
            if (act !== c.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d actual=%h expected=%h", c.name, cyc, act, c.exp);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] exp, input string name);
        chk_t c;
        c.cyc  = cyc;
        c.sel  = sel;
        c.exp  = exp;
        c.name = name;
        q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] BYP_EXP =
`ifdef REGFILE_WRITE_BYPASS_EN
        32'hA5A5A5A5;
`else
        32'h00000001;
`endif

    initial begin
        reset = 1'b1; RegWrite = 1'b0; RegRead = 1'b0;
        ReadReg1 = '0; ReadReg2 = '0; WriteReg = '0; WriteData = '0;
        s_reset = 1'b1; s_we = 1'b0; s_re = 1'b0;
        s_ra1 = '0; s_ra2 = '0; s_wa = '0; s_wd = '0;

        // Initial reset and clear
        tick();
        expect_val(2, 32'd0, "reset_ready");
        reset = 1'b0;
        RegRead = 1'b1;
        ReadReg1 = 5'd9;
        for (int i = 1; i <= 32; i++) begin
            tick();
            expect_val(2, (i == 32) ? 32'd1 : 32'd0, "init_clear_ready");
            if (i < 32) expect_val(0, 32'd0, "init_clear_rd1");
        end
        expect_val(4, 32'd1, "z_ready");

        // Basic write and read
        RegRead = 1'b0;
        RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF;
        tick();
        WriteReg = 5'd31; WriteData = 32'h12345678;
        tick();
        RegWrite = 1'b0; RegRead = 1'b1; ReadReg1 = 5'd5; ReadReg2 = 5'd31;
        expect_val(0, 32'hDEADBEEF, "rd1_reg5");
        expect_val(1, 32'h12345678, "rd2_reg31");
        expect_val(3, 32'hDEADBEEF, "z_rd1_reg5");
        tick();
        RegRead = 1'b0;
        expect_val(0, 32'd0, "rd1_disabled");
        expect_val(1, 32'd0, "rd2_disabled");
        tick();

        // Zero register
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF;
        RegRead = 1'b1; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        expect_val(0, 32'd0, "zero_reg_during_write");
        tick();
        RegWrite = 1'b0;
        expect_val(0, 32'd0, "zero_reg_rd1");
        expect_val(1, 32'd0, "zero_reg_rd2");
        expect_val(3, 32'hFFFFFFFF, "ordinary_reg0");
        tick();

        // Same-cycle read during write
        RegRead = 1'b0;
        RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h00000001;
        tick();
        WriteData = 32'hA5A5A5A5;
        RegRead = 1'b1; ReadReg1 = 5'd7; ReadReg2 = 5'd5;
        expect_val(0, BYP_EXP, "rdw_rd1");
        expect_val(1, 32'hDEADBEEF, "rdw_rd2_other");
        expect_val(3, BYP_EXP, "z_rdw_rd1");
        tick();
        RegWrite = 1'b0;
        expect_val(0, 32'hA5A5A5A5, "rdw_next_cycle");
        tick();

        // Reset from RUN: clear timing and full wipe
        reset = 1'b1; ReadReg1 = 5'd5;
        tick();
        expect_val(2, 32'd0, "rerun_reset_ready");
        expect_val(0, 32'd0, "rerun_reset_rd1");
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            expect_val(2, (i == 32) ? 32'd1 : 32'd0, "clear_ready");
            if (i < 32) expect_val(0, 32'd0, "clear_rd1");
        end
        for (int a = 0; a < 32; a++) begin
            ReadReg1 = 5'(a);
            ReadReg2 = 5'(31 - a);
            expect_val(0, 32'd0, "wiped_rd1");
            expect_val(1, 32'd0, "wiped_rd2");
            expect_val(3, 32'd0, "z_wiped_rd1");
            tick();
        end

        // Reset mid-clear, with writes dropped while clearing
        RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h00000055;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            expect_val(2, 32'd0, "pre_restart_ready");
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            expect_val(2, (i == 32) ? 32'd1 : 32'd0, "restart_ready");
            if (i == 32) RegWrite = 1'b0;
        end
        ReadReg1 = 5'd3;
        expect_val(0, 32'd0, "dropped_write_reg3");
        expect_val(3, 32'd0, "z_dropped_write_reg3");
        tick();

        // Narrow variant: 16-bit data, 8 registers
        tick();
        expect_val(6, 32'd0, "s_reset_ready");
        s_reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            expect_val(6, (i == 8) ? 32'd1 : 32'd0, "s_clear_ready");
        end
        s_we = 1'b1; s_wa = 3'd7; s_wd = 16'hBEEF;
        tick();
        s_we = 1'b0; s_re = 1'b1; s_ra1 = 3'd7;
        expect_val(5, 32'h0000BEEF, "s_rd1_reg7");
        tick();
        s_ra1 = 3'd6;
        expect_val(5, 32'd0, "s_rd1_reg6");
        tick();

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            $display("FAIL unchecked_expectations actual=%0d expected=0", q.size());
            failures += q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised general-purpose register file for the MIPS datapath. It is the successor to the fixed 32x32 file, with the following changes:
- configurable width and depth;
- optional hardwired-zero register 0;
- a synchronous reset clear sequencer, replacing file-based initialisation;
- a ready flag that stalls the core until clearing completes.

It sits between decode (two read ports) and writeback (one write port).

Parameters:
DATA_WIDTH, 32, bit width of each register and data port
ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
RegWrite  input  1  write enable
RegRead  input  1  read enable; when 0 both read outputs are 0
ReadReg1  input  ADDR_WIDTH  read port 1 address
ReadReg2  input  ADDR_WIDTH  read port 2 address
WriteReg  input  ADDR_WIDTH  write address
WriteData  input  DATA_WIDTH  write data
ReadData1  output  DATA_WIDTH  read port 1 data
ReadData2  output  DATA_WIDTH  read port 2 data
ready  output  1  1 = clear complete, file usable

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled only on the clk rising edge.
- State machine: states CLEAR and RUN, plus counter clr_cnt (ADDR_WIDTH bits).
- Reset: on any edge with reset=1, state<=CLEAR, clr_cnt<=0, ready<=0. Register array contents are not touched on that edge.
  - Reset asserted mid-CLEAR restarts clearing at address 0.
  - Reset asserted in RUN discards all contents once clearing reruns.
- CLEAR, each edge with reset=0:
  - register[clr_cnt]<=0 and clr_cnt<=clr_cnt+1.
  - On the edge where clr_cnt==DEPTH-1: state<=RUN, ready<=1, clr_cnt wraps to 0.
  - ready therefore rises exactly DEPTH edges after reset deasserts (32 with defaults).
- CLEAR, other rules:
  - RegWrite is ignored; the external write is dropped, not queued.
  - ReadData1/2 = 0 regardless of address or RegRead.
- RUN, writes: on an edge with RegWrite=1, register[WriteReg]<=WriteData. When ZERO_REG=1 and WriteReg==0, the write is discarded.
- RUN, reads: combinational.
  - ReadDataN = RegRead ? register[ReadRegN] : 0.
  - When ZERO_REG=1 and ReadRegN==0, ReadDataN = 0.
  - Both ports may address the same register; both return the same value.
- Read during write, same address, same cycle: governed by the optional feature below. The array itself always updates at the edge.
- Reset value of outputs:
  - ready=0 from the first reset edge until CLEAR completes.
  - ReadData1/2=0 throughout CLEAR.
  - Before the first reset edge, all outputs are undefined; the bench must apply reset first.
- No arithmetic beyond clr_cnt increment, which is modulo DEPTH.

Optional Feature:
Macro: REGFILE_WRITE_BYPASS_EN
- Defined: in RUN, if RegWrite=1, RegRead=1, ReadRegN==WriteReg, and the write is not discarded by ZERO_REG, then ReadDataN = WriteData combinationally in the same cycle (write-before-read forwarding).
- Not defined: ReadDataN returns the pre-edge register contents; the new value is visible from the cycle after the edge.
- In CLEAR, outputs are 0 regardless.

Test Plan:
1. Reset clear: pre-fill regs via a prior RUN phase, then reset=1 for 1 cycle and release -> ready=0 for 31 edges, 1 on 32nd. Then every address reads 0x00000000.
2. Basic write/read, RUN: write 0xDEADBEEF to reg 5 and 0x12345678 to reg 31; ReadReg1=5, ReadReg2=31, RegRead=1 -> 0xDEADBEEF / 0x12345678. With RegRead=0 -> both 0.
3. Zero register, ZERO_REG=1: write 0xFFFFFFFF to reg 0 -> reads 0. Rerun with ZERO_REG=0 -> reads 0xFFFFFFFF.
4. Bypass: same-cycle RegWrite reg 7=0xA5A5A5A5 with ReadReg1=7, reg 7 previously 0x1.
   - With REGFILE_WRITE_BYPASS_EN: ReadData1=0xA5A5A5A5 that cycle.
   - Without: 0x00000001 that cycle, 0xA5A5A5A5 next.
5. Reset mid-clear: assert reset 10 edges into CLEAR -> ready stays 0 and rises exactly 32 edges after the second release.
   - RegWrite to reg 3=0x55 issued during CLEAR is dropped: reg 3 reads 0 after ready.
6. Parametrised: DATA_WIDTH=16, ADDR_WIDTH=3 -> ready after 8 edges; write 0xBEEF to reg 7, read back 0xBEEF.
